// File: rtl/nbit_nand_sequencer.sv
// Multi-cycle bitwise logic unit: every two-operand function is built from a
// sequence of N-bit NAND evaluations through one shared NAND stage.
module nbit_nand_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_T1, SEL_T2} sel_t;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_RES} dst_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, t1_q, t1_d, t2_q, t2_d;
  logic [N-1:0] result_q, result_d;
  logic [2:0]   op_q, op_d, s_q, s_d;
  logic         done_q, done_d;

  sel_t         x_sel, y_sel;
  dst_t         dst;
  logic [N-1:0] x_val, y_val, nand_out;

  // Step schedule: operand sources and destination for (op, step).
  // A step whose destination is DST_RES is the last step of the op.
  always_comb begin
    x_sel = SEL_A;
    y_sel = SEL_B;
    dst   = DST_RES;
    case (op_q)
      3'b000: ;
      3'b001, 3'b111: begin
        if (op_q == 3'b111) y_sel = SEL_A;
        if (s_q == 3'd0) dst = DST_T1;
        else begin x_sel = SEL_T1; y_sel = SEL_T1; end
      end
      3'b010, 3'b011: begin
        case (s_q)
          3'd0:    begin y_sel = SEL_A; dst = DST_T1; end
          3'd1:    begin x_sel = SEL_B; dst = DST_T2; end
          3'd2:    begin
            x_sel = SEL_T1; y_sel = SEL_T2;
            if (op_q == 3'b011) dst = DST_T1;
          end
          default: begin x_sel = SEL_T1; y_sel = SEL_T1; end
        endcase
      end
      3'b100, 3'b101: begin
        case (s_q)
          3'd0:    dst = DST_T1;
          3'd1:    begin y_sel = SEL_T1; dst = DST_T2; end
          3'd2:    begin x_sel = SEL_B; y_sel = SEL_T1; dst = DST_T1; end
          3'd3:    begin
            x_sel = SEL_T2; y_sel = SEL_T1;
            if (op_q == 3'b101) dst = DST_T1;
          end
          default: begin x_sel = SEL_T1; y_sel = SEL_T1; end
        endcase
      end
      3'b110: y_sel = SEL_A;
    endcase
  end

  always_comb begin
    case (x_sel)
      SEL_A:   x_val = a_q;
      SEL_B:   x_val = b_q;
      SEL_T1:  x_val = t1_q;
      default: x_val = t2_q;
    endcase
    case (y_sel)
      SEL_A:   y_val = a_q;
      SEL_B:   y_val = b_q;
      SEL_T1:  y_val = t1_q;
      default: y_val = t2_q;
    endcase
    nand_out = ~(x_val & y_val);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    s_d      = s_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          s_d     = 3'd0;
          state_d = RUN;
        end
      end
      default: begin
        s_d = s_q + 3'd1;
        case (dst)
          DST_T1:  t1_d = nand_out;
          DST_T2:  t2_d = nand_out;
          default: begin
            result_d = nand_out;
            done_d   = 1'b1;
            s_d      = 3'd0;
            state_d  = IDLE;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
      t1_q     <= '0;
      t2_q     <= '0;
      s_q      <= 3'd0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      s_q      <= s_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_nbit_nand_sequencer.sv
// Directed bench: three widths (1, 8, 32) share one stimulus stream.
module tb_nbit_nand_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy1, done1, busy8, done8, busy32, done32;
  logic [0:0]  res1;
  logic [7:0]  res8;
  logic [31:0] res32;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  nbit_nand_sequencer #(.N(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a[0:0]), .b(b[0:0]),
    .busy(busy1), .done(done1), .result(res1));
  nbit_nand_sequencer #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .result(res8));
  nbit_nand_sequencer #(.N(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(res32));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input int w);
    if (w == 1) return {31'b0, res1};
    if (w == 8) return {24'b0, res8};
    return res32;
  endfunction

  function automatic logic [31:0] done_of(input int w);
    if (w == 1) return {31'b0, done1};
    if (w == 8) return {31'b0, done8};
    return {31'b0, done32};
  endfunction

  // Starts an op and checks done timing/result; returns #1 after the done edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int k, input logic [31:0] exp, input int w);
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0;
    chk({tag, ".busy"}, {31'b0, busy8}, 32'd1);
    for (int i = 1; i <= k; i++) begin
      step();
      if (i < k) chk({tag, ".early_done"}, done_of(w), 32'd0);
    end
    chk({tag, ".done"}, done_of(w), 32'd1);
    chk({tag, ".result"}, res_of(w), exp);
  endtask

  task automatic idle_chk(input string tag, input int w);
    step();
    chk({tag, ".done_fall"}, done_of(w), 32'd0);
    chk({tag, ".idle"}, {31'b0, busy8}, 32'd0);
  endtask

  function automatic logic ref_bit(input logic [2:0] o, input logic x, input logic y);
    case (o)
      3'b000:  return ~(x & y);
      3'b001:  return x & y;
      3'b010:  return x | y;
      3'b011:  return ~(x | y);
      3'b100:  return x ^ y;
      3'b101:  return ~(x ^ y);
      3'b110:  return ~x;
      default: return x;
    endcase
  endfunction

  initial begin
    logic [7:0] exp8 [8];
    int         kk [8];
    exp8 = '{8'h7E, 8'h81, 8'hE7, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hC3};
    kk   = '{1, 2, 3, 4, 4, 5, 1, 2};

    // Reset held with start asserted: nothing may start.
    rst = 1'b1; start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step(); step();
    chk("rst.busy", {29'b0, busy1, busy8, busy32}, 32'd0);
    chk("rst.done", {29'b0, done1, done8, done32}, 32'd0);
    chk("rst.res8", {24'b0, res8}, 32'd0);
    chk("rst.res32", res32, 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("post_rst.busy", {31'b0, busy8}, 32'd0);

    // All ops at N=8 with a=C3, b=A5.
    for (int o = 0; o < 8; o++) begin
      run_op($sformatf("op%0d", o), o[2:0], 32'hC3, 32'hA5, kk[o], {24'b0, exp8[o]}, 8);
      idle_chk($sformatf("op%0d", o), 8);
    end

    // start while busy is ignored.
    start = 1'b1; op = 3'b100; a = 32'hFF; b = 32'h0F;
    step();                                   // E0
    start = 1'b0;
    step();                                   // E1
    start = 1'b1; op = 3'b001; a = 32'h00; b = 32'h00;
    step();                                   // E2, ignored start
    start = 1'b0;
    chk("ign.e2_done", {31'b0, done8}, 32'd0);
    step();                                   // E3
    chk("ign.e3_done", {31'b0, done8}, 32'd0);
    step();                                   // E4
    chk("ign.e4_done", {31'b0, done8}, 32'd1);
    chk("ign.result", {24'b0, res8}, 32'hF0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ign.no_second_done", {31'b0, done8}, 32'd0);
    end
    chk("ign.result_hold", {24'b0, res8}, 32'hF0);

    // Back-to-back: second start lands in the done cycle of the first.
    run_op("b2b.nand", 3'b000, 32'hFF, 32'hFF, 1, 32'h00, 8);
    run_op("b2b.or", 3'b010, 32'h01, 32'h02, 3, 32'h03, 8);
    idle_chk("b2b", 8);

    // Mid-op reset aborts XNOR.
    start = 1'b1; op = 3'b101; a = 32'hC3; b = 32'hA5;
    step();                                   // E0
    start = 1'b0;
    step(); step();                           // E1, E2
    rst = 1'b1;
    step();                                   // E3 with rst
    rst = 1'b0;
    chk("abort.busy", {31'b0, busy8}, 32'd0);
    chk("abort.result", {24'b0, res8}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort.no_done", {31'b0, done8}, 32'd0);
      step();
    end
    chk("abort.result_hold", {24'b0, res8}, 32'd0);
    run_op("after_abort.not", 3'b110, 32'h55, 32'h00, 1, 32'hAA, 8);
    idle_chk("after_abort", 8);

    // N=1 exhaustive.
    for (int o = 0; o < 8; o++)
      for (int p = 0; p < 4; p++) begin
        logic x, y;
        x = p[1]; y = p[0];
        run_op($sformatf("n1.op%0d.%0d%0d", o, x, y), o[2:0], {31'b0, x}, {31'b0, y},
               kk[o], {31'b0, ref_bit(o[2:0], x, y)}, 1);
      end
    idle_chk("n1", 1);

    // N=32 extreme XOR.
    run_op("n32.xor", 3'b100, 32'hFFFF_FFFF, 32'h8000_0001, 4, 32'h7FFF_FFFE, 32);
    idle_chk("n32", 32);
    run_op("n32.xnor", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5, 32'h8000_0001, 32);
    idle_chk("n32b", 32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
